bit_stream_unpacker: RTL and testbench

Streaming bit-field extractor that accepts fixed-width words on a valid/ready input channel and returns variable-length fields, LSB-first, on a valid/ready output channel. It buffers up to two words, and a right barrel shift (pad 0, `2*WIDTH` wide) realigns the remaining bits after every extraction. It sits between a word-oriented source (FIFO, bus reader) and any consumer of packed variable-length fields (decoders, header parsers).

---
 rtl/bit_stream_unpacker.sv | 85 ++++++++
 tb/tb_bit_stream_unpacker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_unpacker.sv
// Streaming bit-field extractor: buffers up to two words and returns LSB-first
// variable-length fields, realigning the residue with a right barrel shift.
module bit_stream_unpacker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WIDTH_LOG2 = $clog2(WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [WIDTH-1:0]        input_data,
  input  logic [WIDTH_LOG2:0]     field_length,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [WIDTH-1:0]        output_data,
  output logic [WIDTH_LOG2+1:0]   bit_count
);

  localparam int unsigned BUF_W = 2 * WIDTH;
  localparam int unsigned CNT_W = WIDTH_LOG2 + 2;
  localparam int unsigned LEN_W = WIDTH_LOG2 + 1;

  logic [BUF_W-1:0] buffer_q;
  logic [BUF_W-1:0] buffer_d;
  logic [BUF_W-1:0] shifted;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_after;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] field_mask;
  logic             push;
  logic             pop;

  // Effective field length, clamped to one word.
  always_comb begin
    if (field_length > LEN_W'(WIDTH)) begin
      len = CNT_W'(WIDTH);
    end else begin
      len = CNT_W'(field_length);
    end
  end

  assign input_ready  = !reset && !flush && (count_q <= CNT_W'(WIDTH));
  assign output_valid = !reset && !flush && (len != '0) && (count_q >= len);
  assign push         = input_valid && input_ready;
  assign pop          = output_valid && output_ready;

  always_comb begin
    field_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      field_mask[i] = (CNT_W'(i) < len);
    end
  end

  assign output_data = buffer_q[WIDTH-1:0] & field_mask;
  assign bit_count   = count_q;

  // Shift out the popped field first, then append the new word behind the residue.
  always_comb begin
    shifted     = buffer_q;
    count_after = count_q;
    if (pop) begin
      shifted     = buffer_q >> len;
      count_after = count_q - len;
    end
    buffer_d = shifted;
    count_d  = count_after;
    if (push) begin
      buffer_d = shifted | (BUF_W'(input_data) << count_after);
      count_d  = count_after + CNT_W'(WIDTH);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      buffer_q <= '0;
      count_q  <= '0;
    end else begin
      buffer_q <= buffer_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_bit_stream_unpacker.sv
// Scoreboard bench for bit_stream_unpacker: expected fields are queued as words
// are driven and checked at each output handshake.
module tb_bit_stream_unpacker;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       input_valid;
  logic       input_ready;
  logic [7:0] input_data;
  logic [3:0] field_length;
  logic       output_valid;
  logic       output_ready;
  logic [7:0] output_data;
  logic [4:0] bit_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  bit_stream_unpacker #(.WIDTH(8), .WIDTH_LOG2(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .field_length (field_length),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .bit_count    (bit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; input_valid = 1'b1; input_data = 8'hFF;
    field_length = 4'd8; output_ready = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if (input_ready !== 1'b0) begin n_fail++; $display("FAIL reset_input_ready: got %b required 0", input_ready); end
      n_checks++;
      if (output_valid !== 1'b0) begin n_fail++; $display("FAIL reset_output_valid: got %b required 0", output_valid); end
      n_checks++;
      if (output_data !== 8'h00) begin n_fail++; $display("FAIL reset_output_data: got %h required 00", output_data); end
      n_checks++;
      if (bit_count !== 5'd0) begin n_fail++; $display("FAIL reset_bit_count: got %0d required 0", bit_count); end
    end
    reset = 1'b0; input_valid = 1'b0;
    #1;
    n_checks++;
    if (input_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", input_ready); end
    n_checks++;
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL post_reset_count: got %0d required 0", bit_count); end
    tick();
  endtask

  task automatic test_nibble();
    int         bc_exp[4] = '{0, 8, 4, 0};
    int         wi = 0;
    logic [7:0] e;
    exp_q.push_back(8'h5); exp_q.push_back(8'hA);
    field_length = 4'd4; output_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      input_valid = (wi < 1); input_data = 8'hA5;
      #1;
      n_checks++;
      if (bit_count !== 5'(bc_exp[c])) begin n_fail++; $display("FAIL nibble_count c%0d: got %0d required %0d", c, bit_count, bc_exp[c]); end
      n_checks++;
      if (output_valid !== (c == 1 || c == 2)) begin n_fail++; $display("FAIL nibble_valid c%0d: got %b", c, output_valid); end
      if (output_valid && output_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL nibble_data: got %h required nothing", output_data); end
        else begin
          e = exp_q.pop_front();
          if (output_data !== e) begin n_fail++; $display("FAIL nibble_data: got %h required %h", output_data, e); end
        end
      end
      if (input_valid && input_ready) wi++;
      tick();
    end
    input_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL nibble_drain: got %0d left required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_odd_fields();
    logic [7:0] words[2] = '{8'hB4, 8'h3C};
    int         wi = 0;
    int         c = 0;
    logic [7:0] e;
    exp_q.push_back(8'd4); exp_q.push_back(8'd6); exp_q.push_back(8'd2);
    exp_q.push_back(8'd6); exp_q.push_back(8'd3);
    field_length = 4'd3; output_ready = 1'b1;
    while (c < 20 && !(wi == 2 && exp_q.size() == 0)) begin
      input_valid = (wi < 2); input_data = (wi < 2) ? words[wi] : 8'h00;
      #1;
      if (output_valid && output_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL odd_data: got %h required nothing", output_data); end
        else begin
          e = exp_q.pop_front();
          if (output_data !== e) begin n_fail++; $display("FAIL odd_data: got %h required %h", output_data, e); end
        end
      end
      if (input_valid && input_ready) wi++;
      tick();
      c++;
    end
    input_valid = 1'b0;
    n_checks++;
    if (c >= 20) begin n_fail++; $display("FAIL odd_timeout: got %0d fields left required 0", exp_q.size()); exp_q.delete(); end
    #1;
    n_checks++;
    if (output_valid !== 1'b0) begin n_fail++; $display("FAIL odd_residual_valid: got %b required 0", output_valid); end
    n_checks++;
    if (bit_count !== 5'd1) begin n_fail++; $display("FAIL odd_residual_count: got %0d required 1", bit_count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL odd_flush_count: got %0d required 0", bit_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words[3] = '{8'h11, 8'h22, 8'h33};
    int         wi = 0;
    logic [7:0] e;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    field_length = 4'd8;
    for (int c = 0; c < 8; c++) begin
      input_valid = (wi < 3); input_data = (wi < 3) ? words[wi] : 8'h00;
      output_ready = (c >= 4);
      #1;
      if (c == 2 || c == 3) begin
        n_checks++;
        if (input_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d: got %b required 0", c, input_ready); end
        n_checks++;
        if (bit_count !== 5'd16) begin n_fail++; $display("FAIL bp_count c%0d: got %0d required 16", c, bit_count); end
        n_checks++;
        if (output_valid !== 1'b1 || output_data !== 8'h11) begin
          n_fail++; $display("FAIL bp_hold c%0d: got valid %b data %h required 1 11", c, output_valid, output_data);
        end
      end
      if (c == 7) begin
        n_checks++;
        if (output_valid !== 1'b0 || bit_count !== 5'd0) begin
          n_fail++; $display("FAIL bp_end: got valid %b count %0d required 0 0", output_valid, bit_count);
        end
      end
      if (output_valid && output_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_data: got %h required nothing", output_data); end
        else begin
          e = exp_q.pop_front();
          if (output_data !== e) begin n_fail++; $display("FAIL bp_data: got %h required %h", output_data, e); end
        end
      end
      if (input_valid && input_ready) begin
        if (wi == 2) begin
          n_checks++;
          if (c != 5) begin n_fail++; $display("FAIL bp_accept_cycle: got %0d required 5", c); end
        end
        wi++;
      end
      tick();
    end
    input_valid = 1'b0; output_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d left required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int         wi = 0;
    logic [7:0] e;
    for (int k = 1; k <= 16; k++) exp_q.push_back(8'(k));
    field_length = 4'd8; output_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      input_valid = (wi < 16); input_data = 8'(wi + 1);
      #1;
      if (c < 16) begin
        n_checks++;
        if (input_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b required 1", c, input_ready); end
      end
      n_checks++;
      if (output_valid !== (c >= 1 && c <= 16)) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b", c, output_valid); end
      n_checks++;
      if (bit_count !== ((c == 0 || c == 17) ? 5'd0 : 5'd8)) begin n_fail++; $display("FAIL b2b_count c%0d: got %0d", c, bit_count); end
      if (output_valid && output_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_data: got %h required nothing", output_data); end
        else begin
          e = exp_q.pop_front();
          if (output_data !== e) begin n_fail++; $display("FAIL b2b_data c%0d: got %h required %h", c, output_data, e); end
        end
      end
      if (input_valid && input_ready) wi++;
      tick();
    end
    input_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d left required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_flush_length();
    logic [7:0] e;
    exp_q.push_back(8'h07);
    field_length = 4'd3; output_ready = 1'b0; input_valid = 1'b1; input_data = 8'hE7;
    tick();
    input_valid = 1'b0; output_ready = 1'b1;
    #1;
    n_checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (!output_valid || output_data !== e) begin n_fail++; $display("FAIL fl_first_field: got %b %h required 1 %h", output_valid, output_data, e); end
    tick();
    output_ready = 1'b0; flush = 1'b1; input_valid = 1'b1; input_data = 8'h5A;
    exp_q.push_back(8'h5A);
    #1;
    n_checks++;
    if (bit_count !== 5'd5) begin n_fail++; $display("FAIL fl_pre_count: got %0d required 5", bit_count); end
    n_checks++;
    if (input_ready !== 1'b0 || output_valid !== 1'b0) begin n_fail++; $display("FAIL fl_masked: got ready %b valid %b required 0 0", input_ready, output_valid); end
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (bit_count !== 5'd0 || input_ready !== 1'b1) begin n_fail++; $display("FAIL fl_post: got count %0d ready %b required 0 1", bit_count, input_ready); end
    tick();
    input_valid = 1'b0; field_length = 4'd0; output_ready = 1'b1;
    #1;
    n_checks++;
    if (bit_count !== 5'd8 || output_valid !== 1'b0) begin n_fail++; $display("FAIL len_zero: got count %0d valid %b required 8 0", bit_count, output_valid); end
    tick();
    n_checks++;
    if (bit_count !== 5'd8) begin n_fail++; $display("FAIL len_zero_hold: got %0d required 8", bit_count); end
    field_length = 4'd12;
    #1;
    n_checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (output_valid !== 1'b1 || output_data !== e) begin n_fail++; $display("FAIL len_clamp: got %b %h required 1 %h", output_valid, output_data, e); end
    tick();
    n_checks++;
    if (bit_count !== 5'd0 || output_valid !== 1'b0) begin n_fail++; $display("FAIL len_clamp_count: got %0d %b required 0 0", bit_count, output_valid); end
    output_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nibble();
    test_odd_fields();
    test_backpressure();
    test_back_to_back();
    test_flush_length();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
